// File: rtl/mul.sv
// mul: iterative radix-2 shift-add 32x32->64 multiplier beside EX, signed/unsigned with annul
// ports: clk, rst (async active-low), signed_mul_i, opdata1_i, opdata2_i, start_i, annul_i -> result_o, ready_o
module mul #(
  parameter int DATA_W = 32,
  parameter int CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_mul_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);
  typedef enum logic [1:0] {FREE, ON, END} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2*DATA_W-1:0] acc, acc_n, mcand, mcand_n, sum, result_n;
  logic [DATA_W-1:0] mplier, mplier_n, abs1, abs2;
  logic neg, neg_n, ready_n;
  assign abs1 = signed_mul_i && opdata1_i[DATA_W-1] ? -opdata1_i : opdata1_i;
  assign abs2 = signed_mul_i && opdata2_i[DATA_W-1] ? -opdata2_i : opdata2_i;
  assign sum = acc + (mplier[0] ? mcand : '0);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    acc_n = acc;
    mcand_n = mcand;
    mplier_n = mplier;
    neg_n = neg;
    result_n = '0;
    ready_n = 1'b0;
    case (state)
      FREE: if (start_i && !annul_i) begin
        neg_n = signed_mul_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
        mcand_n = {{DATA_W{1'b0}}, abs1};
        mplier_n = abs2;
        acc_n = '0;
        cnt_n = '0;
        state_n = (abs1 == '0 || abs2 == '0) ? END : ON;
        ready_n = (abs1 == '0 || abs2 == '0);
      end
      ON: if (annul_i) begin
        state_n = FREE;
        acc_n = '0;
      end else begin
        acc_n = sum;
        mcand_n = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(DATA_W-1)) begin
          state_n = END;
          result_n = neg ? -sum : sum;
          ready_n = 1'b1;
        end
      end
      END: if (annul_i || !start_i) state_n = FREE;
      else begin
        result_n = result_o;
        ready_n = 1'b1;
      end
      default: state_n = FREE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= FREE;
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      neg <= 1'b0;
      result_o <= '0;
      ready_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      acc <= acc_n;
      mcand <= mcand_n;
      mplier <= mplier_n;
      neg <= neg_n;
      result_o <= result_n;
      ready_o <= ready_n;
    end
endmodule

// File: tb/tb_mul.sv
// tb_mul: randomized self-checking bench for mul against an arithmetic product model
module tb_mul;
  logic clk = 0, rst = 0, signed_mul_i = 0, start_i = 0, annul_i = 0;
  logic [31:0] opdata1_i = 0, opdata2_i = 0;
  logic [63:0] result_o;
  logic ready_o;
  int n_cmp = 0, n_bad = 0;
  mul dut (.clk(clk), .rst(rst), .signed_mul_i(signed_mul_i), .opdata1_i(opdata1_i),
           .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
           .result_o(result_o), .ready_o(ready_o));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return s ? 64'(sa * sb) : {32'h0, a} * {32'h0, b};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [63:0] exp;
    exp = ref_mul(s, a, b);
    lat = (a == 0 || b == 0) ? 1 : 33;
    signed_mul_i = s;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1;
    for (int i = 1; i <= lat; i++) begin
      tick();
      if (i < lat) check("busy", {63'h0, ready_o}, 64'h0);
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      signed_mul_i = 1'($urandom);
    end
    check("ready", {63'h0, ready_o}, 64'h1);
    check("result", result_o, exp);
    tick();
    check("hold_ready", {63'h0, ready_o}, 64'h1);
    check("hold_result", result_o, exp);
    start_i = 0;
    tick();
    check("drop_ready", {63'h0, ready_o}, 64'h0);
    check("drop_result", result_o, 64'h0);
  endtask
  initial begin
    #1;
    check("rst_ready", {63'h0, ready_o}, 64'h0);
    check("rst_result", result_o, 64'h0);
    tick();
    rst = 1;
    run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("const_ffff", ref_mul(0, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE00000001);
    run_op(1, 32'hFFFFFFFD, 32'h7);
    run_op(0, 32'hFFFFFFFD, 32'h7);
    run_op(1, 32'h80000000, 32'h80000000);
    run_op(1, 32'h80000000, 32'h1);
    run_op(0, 32'h0, 32'h12345678);
    run_op(1, 32'h0, 32'h12345678);
    run_op(1, 32'h5, 32'h0);
    signed_mul_i = 0;
    opdata1_i = 32'h1234;
    opdata2_i = 32'h5678;
    start_i = 1;
    for (int i = 1; i < 10; i++) tick();
    annul_i = 1;
    tick();
    annul_i = 0;
    start_i = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready_o) check("annul_ready", {63'h0, ready_o}, 64'h0);
    end
    check("annul_idle", {63'h0, ready_o}, 64'h0);
    run_op(0, 32'd6, 32'd7);
    opdata1_i = 32'd9;
    opdata2_i = 32'd9;
    start_i = 1;
    for (int i = 0; i < 6; i++) tick();
    #2 rst = 0;
    #1;
    check("async_ready", {63'h0, ready_o}, 64'h0);
    check("async_result", result_o, 64'h0);
    start_i = 0;
    tick();
    rst = 1;
    tick();
    run_op(0, 32'd2, 32'd3);
    for (int k = 0; k < 24; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 0;
      if ($urandom_range(0, 7) == 0) b = 32'h80000000;
      run_op(1'($urandom), a, b);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
